mips_muldiv_unit: RTL and testbench

//  Iterative multiply/divide unit in the EX stage, beside the ALU. Executes

---
 rtl/mips_muldiv_if.sv | 31 +++
 rtl/mips_muldiv_unit.sv | 193 +++++++++++++++++++
 tb/tb_mips_muldiv_unit.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/mips_muldiv_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Interface : mips_muldiv_if                                           |
// | Purpose   : request/response bundle between the EX stage control     |
// |             and the iterative multiply/divide unit.                  |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
interface mips_muldiv_if #(
  parameter int WIDTH = 32
);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (
    output start, op, a, b, flush,
    input  busy, done, hi, lo
  );

  modport slave (
    input  start, op, a, b, flush,
    output busy, done, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : mips_muldiv_unit                                         |
// | Purpose   : iterative MULT/MULTU/DIV/DIVU unit with HI/LO registers  |
// |             and MTHI/MTLO writes; one bit per clock, WIDTH clocks of |
// |             iteration plus one finishing clock.                      |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module mips_muldiv_unit #(
  parameter int WIDTH = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  mips_muldiv_if.slave  bus
);

  localparam int              c_cnt_w    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(WIDTH - 1);

  localparam logic [2:0] c_op_mult  = 3'd0;
  localparam logic [2:0] c_op_multu = 3'd1;
  localparam logic [2:0] c_op_div   = 3'd2;
  localparam logic [2:0] c_op_divu  = 3'd3;
  localparam logic [2:0] c_op_mthi  = 3'd4;
  localparam logic [2:0] c_op_mtlo  = 3'd5;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [c_cnt_w-1:0]    r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [WIDTH-1:0]      r_hi;
  logic [WIDTH-1:0]      r_lo;
  // Upper half: partial product / partial remainder.
  // Lower half: multiplier / dividend shifting out, quotient shifting in.
  logic [2*WIDTH-1:0]    r_acc;
  logic [WIDTH-1:0]      r_opm;     // multiplicand or divisor magnitude
  logic [WIDTH-1:0]      r_a_orig;  // unmodified dividend for divide-by-zero
  logic                  r_is_div;
  logic                  r_sign_q;
  logic                  r_sign_r;
  logic                  r_div0;

  logic                  w_signed_op;
  logic                  w_div_op;
  logic                  w_muldiv_op;
  logic [WIDTH-1:0]      w_abs_a;
  logic [WIDTH-1:0]      w_abs_b;
  logic [WIDTH:0]        w_mul_sum;
  logic [WIDTH:0]        w_div_shift;
  logic                  w_div_ge;
  logic [WIDTH-1:0]      w_div_diff;
  logic [WIDTH-1:0]      w_div_rem;
  logic [2*WIDTH-1:0]    w_prod_fix;
  logic [WIDTH-1:0]      w_quo_fix;
  logic [WIDTH-1:0]      w_rem_fix;

  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.hi   = r_hi;
  assign bus.lo   = r_lo;

  // Decode the requested operation and form operand magnitudes.
  always_comb begin
    w_signed_op = (bus.op == c_op_mult) || (bus.op == c_op_div);
    w_div_op    = (bus.op == c_op_div)  || (bus.op == c_op_divu);
    w_muldiv_op = (bus.op == c_op_mult) || (bus.op == c_op_multu) || w_div_op;
    w_abs_a     = (w_signed_op && bus.a[WIDTH-1]) ? (~bus.a + 1'b1) : bus.a;
    w_abs_b     = (w_signed_op && bus.b[WIDTH-1]) ? (~bus.b + 1'b1) : bus.b;
  end

  // One shift-add multiply step and one restoring-divide step per clock.
  always_comb begin
    w_mul_sum   = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, (r_acc[0] ? r_opm : {WIDTH{1'b0}})};
    w_div_shift = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    w_div_ge    = (w_div_shift >= {1'b0, r_opm});
    // Only used when the shifted remainder is at least the divisor, so the
    // true difference is below the divisor and fits in WIDTH bits.
    w_div_diff  = w_div_shift[WIDTH-1:0] - r_opm;
    w_div_rem   = w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
  end

  // Sign fixups applied when the result is committed.
  always_comb begin
    w_prod_fix = r_sign_q ? (~r_acc + 1'b1) : r_acc;
    w_quo_fix  = r_sign_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_rem_fix  = r_sign_r ? (~r_acc[2*WIDTH-1:WIDTH] + 1'b1) : r_acc[2*WIDTH-1:WIDTH];
  end

  // Next-state logic; flush always returns to IDLE and beats FINISH.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.start && !bus.flush && w_muldiv_op) begin
          w_state_nxt = S_CALC;
        end
      end
      S_CALC: begin
        if (bus.flush) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == c_cnt_last) begin
          w_state_nxt = S_FINISH;
        end
      end
      S_FINISH: w_state_nxt = S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  // State register and the registered busy flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != S_IDLE);
    end
  end

  // Datapath: operand capture, iteration, result commit and done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt    <= '0;
      r_done   <= 1'b0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_acc    <= '0;
      r_opm    <= '0;
      r_a_orig <= '0;
      r_is_div <= 1'b0;
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_div0   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start && !bus.flush) begin
            if (bus.op == c_op_mthi) begin
              r_hi <= bus.a;
            end else if (bus.op == c_op_mtlo) begin
              r_lo <= bus.a;
            end else if (w_muldiv_op) begin
              r_cnt    <= '0;
              r_is_div <= w_div_op;
              r_opm    <= w_div_op ? w_abs_b : w_abs_a;
              r_acc    <= {{WIDTH{1'b0}}, (w_div_op ? w_abs_a : w_abs_b)};
              r_a_orig <= bus.a;
              r_sign_q <= w_signed_op && (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
              r_sign_r <= w_signed_op && bus.a[WIDTH-1];
              r_div0   <= (bus.b == {WIDTH{1'b0}});
            end
          end
        end
        S_CALC: begin
          if (!bus.flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_is_div) begin
              r_acc <= {w_div_rem, r_acc[WIDTH-2:0], w_div_ge};
            end else begin
              r_acc <= {w_mul_sum, r_acc[WIDTH-1:1]};
            end
          end
        end
        S_FINISH: begin
          if (!bus.flush) begin
            r_done <= 1'b1;
            if (!r_is_div) begin
              {r_hi, r_lo} <= w_prod_fix;
            end else if (r_div0) begin
              r_hi <= r_a_orig;
              r_lo <= {WIDTH{1'b1}};
            end else begin
              r_hi <= w_rem_fix;
              r_lo <= w_quo_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module    : tb_mips_muldiv_unit                                      |
// | Purpose   : randomized and directed bench for mips_muldiv_unit with  |
// |             a transaction-level reference model.                     |
// | Revision  : 1.0 - initial release                                    |
// +----------------------------------------------------------------------+
module tb_mips_muldiv_unit;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  mips_muldiv_if #(.WIDTH(W)) bus();

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  // Architectural result of a mul/div: {HI, LO}.
  function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    res = '0;
    case (op)
      3'd0: res = 64'(sa * sb);
      3'd1: res = {32'b0, a} * {32'b0, b};
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
          res = {a, 32'hFFFF_FFFF};
        end else if (op == 3'd2) begin
          q   = sa / sb;
          r   = sa % sb;
          res = {r[31:0], q[31:0]};
        end else begin
          res = {a % b, a / b};
        end
      end
      default: res = '0;
    endcase
    return res;
  endfunction

  // Reference model: an accepted mul/div completes 33 edges later.
  logic        m_busy, m_done;
  logic [31:0] m_hi, m_lo, m_rhi, m_rlo;
  int          m_left;

  // Track the expected architectural state edge by edge.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_done <= 1'b0; m_hi <= '0; m_lo <= '0;
      m_rhi  <= '0;   m_rlo  <= '0;   m_left <= 0;
    end else begin
      m_done <= 1'b0;
      if (m_busy) begin
        if (bus.flush) begin
          m_busy <= 1'b0;
        end else if (m_left == 1) begin
          m_hi <= m_rhi; m_lo <= m_rlo; m_done <= 1'b1; m_busy <= 1'b0;
        end else begin
          m_left <= m_left - 1;
        end
      end else if (bus.start && !bus.flush) begin
        case (bus.op)
          3'd4: m_hi <= bus.a;
          3'd5: m_lo <= bus.a;
          3'd0, 3'd1, 3'd2, 3'd3: begin
            {m_rhi, m_rlo} <= ref_result(bus.op, bus.a, bus.b);
            m_busy <= 1'b1;
            m_left <= 33;
          end
          default: ;
        endcase
      end
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    checks++;
    if ({bus.busy, bus.done, bus.hi, bus.lo} !== {m_busy, m_done, m_hi, m_lo}) begin
      errors++;
      $display("FAIL cycle_cmp t=%0t busy=%b done=%b hi=%h lo=%h expected busy=%b done=%b hi=%h lo=%h",
               $time, bus.busy, bus.done, bus.hi, bus.lo, m_busy, m_done, m_hi, m_lo);
    end
  end

  task automatic chk(input string name, input logic [65:0] act, input logic [65:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    bus.start = 1'b1; bus.op = op; bus.a = a; bus.b = b;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [63:0] exp);
    int  n;
    bit  seen;
    n = 0; seen = 1'b0;
    do_op(op, a, b);
    while (n < 100 && !seen) begin
      tick();
      n++;
      if (bus.done) seen = 1'b1;
    end
    chk({name, "_latency"}, 66'(n), 66'd33);
    chk({name, "_hilo"}, {2'b00, bus.hi, bus.lo}, {2'b00, exp});
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    bus.start = 1'b0; bus.op = 3'd0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
    rst_n = 1'b1;
    tick();

    // Pin the reference model to hand-computed values.
    chk("ref_mult",  {2'b00, ref_result(3'd0, 32'hFFFF_FFFF, 32'd2)}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFE});
    chk("ref_multu", {2'b00, ref_result(3'd1, 32'hFFFF_FFFF, 32'd2)}, {2'b00, 64'h0000_0001_FFFF_FFFE});
    chk("ref_div",   {2'b00, ref_result(3'd2, 32'hFFFF_FFF9, 32'd2)}, {2'b00, 64'hFFFF_FFFF_FFFF_FFFD});
    chk("ref_divu0", {2'b00, ref_result(3'd3, 32'd7, 32'd0)},         {2'b00, 64'h0000_0007_FFFF_FFFF});
    chk("ref_ovf",   {2'b00, ref_result(3'd2, 32'h8000_0000, 32'hFFFF_FFFF)}, {2'b00, 64'h0000_0000_8000_0000});

    // Directed operations with literal expectations.
    run_op("mult",   3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    run_op("multu",  3'd1, 32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);
    run_op("div",    3'd2, 32'hFFFF_FFF9, 32'd2, 64'hFFFF_FFFF_FFFF_FFFD);
    run_op("divu0",  3'd3, 32'd7, 32'd0, 64'h0000_0007_FFFF_FFFF);
    run_op("divovf", 3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    run_op("divs0",  3'd2, 32'hFFFF_FFF9, 32'd0, 64'hFFFF_FFF9_FFFF_FFFF);

    // mthi in IDLE, then mthi while busy is ignored.
    do_op(3'd4, 32'h1234_5678, 32'd0);
    chk("mthi_idle", {bus.done, bus.hi}, {1'b0, 32'h1234_5678});
    do_op(3'd0, 32'd3, 32'd5);
    repeat (4) tick();
    do_op(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_busy", {2'b00, bus.hi}, {2'b00, 32'h1234_5678});
    repeat (40) tick();
    chk("mult_after_mthi", {2'b00, bus.hi, bus.lo}, {2'b00, 32'd0, 32'd15});

    // Flush in the middle of a divide.
    do_op(3'd2, 32'd100, 32'd7);
    repeat (9) tick();
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_busy", 66'(bus.busy), 66'd0);
    repeat (40) tick();
    chk("flush_hilo", {2'b00, bus.hi, bus.lo}, {2'b00, 32'd0, 32'd15});

    // Flush with start in IDLE drops an mthi.
    bus.flush = 1'b1;
    do_op(3'd4, 32'hAAAA_5555, 32'd0);
    bus.flush = 1'b0;
    chk("flush_idle_mthi", {2'b00, bus.hi}, 66'd0);

    // Flush coinciding with FINISH suppresses the write.
    do_op(3'd1, 32'd6, 32'd7);
    repeat (32) tick();
    chk("finish_busy", 66'(bus.busy), 66'd1);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    chk("flush_finish", {bus.busy, bus.done, bus.hi, bus.lo}, {2'b00, 32'd0, 32'd15});
    repeat (3) tick();

    // Randomized traffic, including starts while busy and stray flushes.
    for (int i = 0; i < 4000; i++) begin
      bus.start = ($urandom_range(0, 99) < 30);
      bus.op    = 3'($urandom_range(0, 7));
      bus.a     = pick();
      bus.b     = pick();
      bus.flush = ($urandom_range(0, 99) < 2);
      tick();
    end
    bus.start = 1'b0; bus.flush = 1'b0;
    repeat (40) tick();

    // Reset in the middle of a multiply, then a full-length multiply.
    run_op("mult_pre", 3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);
    do_op(3'd0, 32'd9, 32'd9);
    repeat (19) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("reset_midop", {bus.busy, bus.done, bus.hi, bus.lo}, 66'd0);
    tick();
    rst_n = 1'b1;
    tick();
    run_op("mult_post", 3'd0, 32'hFFFF_FFFF, 32'd2, 64'hFFFF_FFFF_FFFF_FFFE);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
